// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generation for the in-order pipeline.
// A private shift-register tracker mirrors in-flight destination writes past ID.

module fwd_src_match #(
  parameter int FWD_DEPTH    = 2,
  parameter int LOAD_FWD_MIN = 1,
  parameter int REG_AW       = 5,
  parameter int SW           = 2
) (
  input  logic                             id_valid,
  input  logic                             rs_used,
  input  logic [REG_AW-1:0]                rs,
  input  logic [FWD_DEPTH-1:0]             e_valid,
  input  logic [FWD_DEPTH-1:0]             e_regwrite,
  input  logic [FWD_DEPTH-1:0]             e_is_load,
  input  logic [FWD_DEPTH-1:0][REG_AW-1:0] e_rd,
  output logic [SW-1:0]                    sel,
  output logic                             hazard
);
  logic [FWD_DEPTH-1:0] hit;

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_hit
    assign hit[k] = id_valid && rs_used && e_valid[k] && e_regwrite[k] &&
                    (e_rd[k] != '0) && (e_rd[k] == rs);
  end

  // Scan oldest to youngest so the youngest producer overrides; a younger
  // load therefore always wins over an older ALU result.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (hit[k]) begin
        sel    = SW'(k+1);
        hazard = e_is_load[k] && (k < LOAD_FWD_MIN);
      end
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int NUM_SRC      = 2,
  parameter int FWD_DEPTH    = 2,
  parameter int LOAD_FWD_MIN = 1,
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 16,
  localparam int SW          = $clog2(FWD_DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic [NUM_SRC*SW-1:0]     fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_count
);
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } trk_t;

  logic [FWD_DEPTH-1:0]             vld_pipe;
  trk_t [FWD_DEPTH-1:0]             trk_q;
  logic [FWD_DEPTH-1:0]             e_rw, e_ld;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] e_rd;
  logic [NUM_SRC-1:0][REG_AW-1:0]   rs_l;
  logic [NUM_SRC-1:0][SW-1:0]       sel_l;
  logic [NUM_SRC-1:0]               haz;
  logic                             issue;

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_unpack
    assign e_rw[k] = trk_q[k].regwrite;
    assign e_ld[k] = trk_q[k].is_load;
    assign e_rd[k] = trk_q[k].rd;
  end

  assign rs_l = id_rs;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .FWD_DEPTH   (FWD_DEPTH),
      .LOAD_FWD_MIN(LOAD_FWD_MIN),
      .REG_AW      (REG_AW),
      .SW          (SW)
    ) u_match (
      .id_valid  (id_valid),
      .rs_used   (id_rs_used[i]),
      .rs        (rs_l[i]),
      .e_valid   (vld_pipe),
      .e_regwrite(e_rw),
      .e_is_load (e_ld),
      .e_rd      (e_rd),
      .sel       (sel_l[i]),
      .hazard    (haz[i])
    );
  end

  assign fwd_sel = sel_l;
  // A redirect squashes the dependent instruction, so there is nothing to wait for.
  assign stall   = (|haz) && !flush;
  assign issue   = id_valid && !stall && !flush;

  // Only the valid bit needs qualifying; payload is ignored behind a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      trk_q    <= '0;
    end else begin
      vld_pipe[0] <= issue;
      trk_q[0]    <= '{rd: id_rd, regwrite: id_regwrite, is_load: id_is_load};
      for (int k = 1; k < FWD_DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        trk_q[k]    <= trk_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end
endmodule
